// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue between an in-order instruction memory and the cpu fetch stage.
// Optional hit/redirect statistics counters are enabled by defining IFQ_STATS_EN.
module inst_prefetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
`ifdef IFQ_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       redirect_cnt
`endif
);

    // state  | meaning
    // IDLE   | no stream yet; first fetch_en seeds the prefetch address
    // RUN    | issuing requests, filling entries and serving hits
    // FLUSH  | dropping responses to requests issued before a redirect

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-3:0]   ent_addr [DEPTH];
    logic [31:0]         ent_data [DEPTH];
    logic [DEPTH-1:0]    ent_filled;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       fill_ptr;
    logic [CW-1:0]       alloc_cnt;
    logic [CW-1:0]       unf_cnt;
    logic [CW-1:0]       discard_cnt;
    logic [ADDR_W-1:0]   pf_addr;

    logic [ADDR_W-3:0]   pc_word;
    logic                pc_lo_unused;
    logic                in_run;
    logic                head_alloc;
    logic                head_filled;
    logic                head_match;
    logic                hit;
    logic                redirect;
    logic                do_alloc;
    logic                do_fill;
    logic [CW-1:0]       unf_after_rv;

    assign pc_word      = pc[ADDR_W-1:2];
    assign pc_lo_unused = ^pc[1:0];
    assign in_run       = (state == S_RUN);
    assign head_alloc   = (alloc_cnt != '0);
    assign head_filled  = head_alloc && ent_filled[rd_ptr];
    assign head_match   = (ent_addr[rd_ptr] == pc_word);

    assign hit      = in_run && fetch_en && head_filled && head_match;
    assign redirect = in_run && fetch_en &&
                      (head_alloc ? !head_match : (pf_addr[ADDR_W-1:2] != pc_word));

    assign mem_req  = in_run && !redirect && (alloc_cnt < CW'(DEPTH));
    assign mem_addr = pf_addr;
    assign do_alloc = mem_req && mem_ack;
    assign do_fill  = in_run && !redirect && mem_rvalid && (unf_cnt != '0);

    // A response arriving in the redirect cycle already accounts for one stale request.
    assign unf_after_rv = (mem_rvalid && (unf_cnt != '0)) ? unf_cnt - CW'(1) : unf_cnt;

    assign inst_valid = hit;
    assign inst       = head_filled ? ent_data[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ent_filled  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            alloc_cnt   <= '0;
            unf_cnt     <= '0;
            discard_cnt <= '0;
            pf_addr     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_en) begin
                        pf_addr <= {pc_word, 2'b00};
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (redirect) begin
                        ent_filled  <= '0;
                        rd_ptr      <= '0;
                        wr_ptr      <= '0;
                        fill_ptr    <= '0;
                        alloc_cnt   <= '0;
                        unf_cnt     <= '0;
                        pf_addr     <= {pc_word, 2'b00};
                        discard_cnt <= unf_after_rv;
                        state       <= (unf_after_rv == '0) ? S_RUN : S_FLUSH;
                    end else begin
                        if (do_alloc) begin
                            ent_filled[wr_ptr] <= 1'b0;
                            wr_ptr             <= wr_ptr + PW'(1);
                            pf_addr            <= pf_addr + ADDR_W'(4);
                        end
                        if (do_fill) begin
                            ent_filled[fill_ptr] <= 1'b1;
                            fill_ptr             <= fill_ptr + PW'(1);
                        end
                        if (hit) begin
                            ent_filled[rd_ptr] <= 1'b0;
                            rd_ptr             <= rd_ptr + PW'(1);
                        end
                        alloc_cnt <= alloc_cnt + CW'(do_alloc) - CW'(hit);
                        unf_cnt   <= unf_cnt + CW'(do_alloc) - CW'(do_fill);
                    end
                end
                S_FLUSH: begin
                    if (mem_rvalid) begin
                        discard_cnt <= discard_cnt - CW'(1);
                        if (discard_cnt <= CW'(1)) begin
                            state <= S_RUN;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in ent_filled and alloc_cnt.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ent_addr[wr_ptr] <= pf_addr[ADDR_W-1:2];
        end
        if (do_fill) begin
            ent_data[fill_ptr] <= mem_rdata;
        end
    end

`ifdef IFQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt      <= '0;
            redirect_cnt <= '0;
        end else begin
            if (hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed testbench for inst_prefetch_queue with an in-order fixed-latency memory model.
// Covers the IFQ_STATS_EN counters when that macro is defined.
module tb_inst_prefetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam logic [31:0] XK = 32'hA5A5A5A5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
`ifdef IFQ_STATS_EN
    logic [15:0]       hit_cnt;
    logic [15:0]       redirect_cnt;
`endif

    always #5 clk = ~clk;

    inst_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid)
`ifdef IFQ_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .redirect_cnt(redirect_cnt)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] acc_addr [$];
    logic        o_req;
    logic        o_iv;
    logic [31:0] o_addr;
    logic [31:0] o_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, present due responses, sample outputs, advance.
    task automatic cycle(input logic rst, input logic fe, input logic [31:0] p);
        reset    = rst;
        fetch_en = fe;
        pc       = p;
        mem_ack  = 1'b1;
        if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = q_addr[0] ^ XK;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        #1;
        o_req  = mem_req;
        o_iv   = inst_valid;
        o_addr = mem_addr;
        o_inst = inst;
        if (mem_req && mem_ack) begin
            q_addr.push_back(mem_addr);
            q_due.push_back(cyc + lat);
            acc_addr.push_back(mem_addr);
        end
        if (mem_rvalid) begin
            q_addr.delete(0);
            q_due.delete(0);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20 && q_addr.size() != 0; i++) cycle(1'b0, 1'b0, 32'h0);
        acc_addr.delete();
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic [31:0] exp_w [4];
        reset = 1'b1; fetch_en = 1'b0; pc = '0;
        mem_ack = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);

        // Reset held with fetch_en high, then cold start and sequential stream at L=1
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 32'h0);
            check("rst_iv", o_iv, 0);
            check("rst_req", o_req, 0);
            check("rst_addr", o_addr, 0);
            check("rst_inst", o_inst, 0);
        end
        cyc = 0;
        cycle(1'b0, 1'b1, 32'h0);
        check("cold_c0_req", o_req, 0);
        check("cold_c0_iv", o_iv, 0);
        cycle(1'b0, 1'b1, 32'h0);
        check("cold_c1_req", o_req, 1);
        check("cold_c1_addr", o_addr, 32'h0);
        check("cold_c1_iv", o_iv, 0);
        cycle(1'b0, 1'b1, 32'h0);
        check("cold_c2_iv", o_iv, 0);
        for (int i = 0; i < 8; i++) begin
            p = 32'(4 * i);
            cycle(1'b0, 1'b1, p);
            check("seq_iv", o_iv, 1);
            check("seq_inst", o_inst, p ^ XK);
        end

        // Redirect with two requests in flight at L=3
        do_reset(2);
        lat = 3;
        cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 32'h0);
        check("rd_c1_addr", o_addr, 32'h0);
        cycle(1'b0, 1'b1, 32'h0);
        check("rd_c2_req", o_req, 1);
        check("rd_c2_addr", o_addr, 32'h4);
        cycle(1'b0, 1'b1, 32'h100);
        check("rd_c3_req", o_req, 0);
        check("rd_c3_iv", o_iv, 0);
        cycle(1'b0, 1'b1, 32'h100);
        check("rd_flush1_req", o_req, 0);
        cycle(1'b0, 1'b1, 32'h100);
        check("rd_flush2_req", o_req, 0);
        cycle(1'b0, 1'b1, 32'h100);
        check("rd_c6_req", o_req, 1);
        check("rd_c6_addr", o_addr, 32'h100);
        for (int i = 7; i < 10; i++) begin
            cycle(1'b0, 1'b1, 32'h100);
            check("rd_wait_iv", o_iv, 0);
        end
        cycle(1'b0, 1'b1, 32'h100);
        check("rd_hit_iv", o_iv, 1);
        check("rd_hit_inst", o_inst, 32'hA5A5A4A5);

        // Back-pressure: no fetches, queue fills to DEPTH then stops requesting
        do_reset(2);
        lat = 1;
        cycle(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);
        check("bp_nreq", acc_addr.size(), 4);
        check("bp_req_off", o_req, 0);
        check("bp_last_addr", acc_addr[3], 32'hC);
        for (int i = 0; i < 4; i++) begin
            p = 32'(4 * i);
            cycle(1'b0, 1'b1, p);
            check("bp_hit_iv", o_iv, 1);
            check("bp_hit_inst", o_inst, p ^ XK);
        end

        // Address wrap across 0xFFFFFFFC -> 0x0 without redirect
        do_reset(2);
        lat = 1;
        exp_w[0] = 32'hFFFFFFF8; exp_w[1] = 32'hFFFFFFFC;
        exp_w[2] = 32'h0;        exp_w[3] = 32'h4;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hFFFFFFF8);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, exp_w[i]);
            check("wrap_iv", o_iv, 1);
            check("wrap_inst", o_inst, exp_w[i] ^ XK);
        end
        check("wrap_nreq", 32'(acc_addr.size() >= 4), 1);
        for (int i = 0; i < 4; i++) check("wrap_addr", acc_addr[i], exp_w[i]);

        // Reset during FLUSH, late response dropped, then normal cold start
        do_reset(2);
        lat = 3;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 32'h100);
        cycle(1'b1, 1'b1, 32'h100);
        cycle(1'b0, 1'b0, 32'h100);
        check("rf_late_req", o_req, 0);
        check("rf_late_iv", o_iv, 0);
        cycle(1'b0, 1'b1, 32'h40);
        check("rf_c0_req", o_req, 0);
        cycle(1'b0, 1'b1, 32'h40);
        check("rf_c1_req", o_req, 1);
        check("rf_c1_addr", o_addr, 32'h40);
        for (int i = 2; i < 5; i++) begin
            cycle(1'b0, 1'b1, 32'h40);
            check("rf_wait_iv", o_iv, 0);
        end
        cycle(1'b0, 1'b1, 32'h40);
        check("rf_hit_iv", o_iv, 1);
        check("rf_hit_inst", o_inst, 32'hA5A5A5E5);

`ifdef IFQ_STATS_EN
        // Five hits then one redirect
        do_reset(2);
        lat = 1;
        check("st_rst_hit", 32'(hit_cnt), 0);
        check("st_rst_redir", 32'(redirect_cnt), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            p = 32'(4 * i);
            cycle(1'b0, 1'b1, p);
            check("st_hit_iv", o_iv, 1);
        end
        cycle(1'b0, 1'b1, 32'h200);
        check("st_redir_iv", o_iv, 0);
        cycle(1'b0, 1'b0, 32'h200);
        check("st_hit_cnt", 32'(hit_cnt), 5);
        check("st_redir_cnt", 32'(redirect_cnt), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue sitting directly upstream of the `cpu` fetch stage, between an in-order, variable-latency instruction memory and the cpu's `pc`/`inst` interface. It streams sequential words ahead of the cpu and serves `inst` with zero added latency when the head entry matches `pc`. On any `pc` discontinuity (taken branch, jump, mispredict recovery) it flushes and drops stale in-flight responses.

## Interface
- `DEPTH`, 4: queue entries and maximum outstanding memory requests; power of two, ≥2
- `ADDR_W`, 32: address width
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `pc` in ADDR_W: cpu fetch address; bits [1:0] ignored (treated as 0)
- `fetch_en` in 1: cpu requests the instruction at `pc` this cycle
- `inst` out 32: instruction for `pc`; combinational from the head entry
- `inst_valid` out 1: `inst` is valid for `pc` this cycle; cpu stalls when low
- `mem_req` out 1: memory read request
- `mem_addr` out ADDR_W: word address of the request
- `mem_ack` in 1: request accepted this cycle
- `mem_rdata` in 32: response data
- `mem_rvalid` in 1: response valid; responses are in order, ≥1 cycle after the ack

## Operation
- Per-entry storage: `addr`, `data`, `filled`. Entries are allocated in FIFO order when a request is accepted. `alloc_cnt` counts entries, 0..DEPTH.
- `pf_addr`: next address to request. It increments by 4 on each accepted request and wraps modulo 2^ADDR_W (0xFFFFFFFC → 0x0).
- FSM states:
  - IDLE (reset state): no requests. On `fetch_en`: `pf_addr ← pc`, go to RUN.
  - RUN:
    - `mem_req = (alloc_cnt < DEPTH)`, using the value at the start of the cycle, and no redirect this cycle. `mem_addr = pf_addr`.
    - `mem_req & mem_ack` allocates at the tail with `filled = 0`.
    - `mem_rvalid` fills the oldest unfilled entry.
  - FLUSH: `mem_req = 0`. Each `mem_rvalid` decrements `discard_cnt` and its data is dropped. Go to RUN in the cycle `discard_cnt` reaches 0.
- Hit: `fetch_en`, head allocated, head `filled`, and `head.addr == pc[ADDR_W-1:2]`. Result: `inst_valid = 1`, `inst = head.data`, head popped at the clock edge.
- Wait: head allocated with a matching address but not yet filled. Result: `inst_valid = 0`, no state change.
- Redirect: `fetch_en` in RUN, and either (head allocated with a mismatching address) or (queue empty and `pf_addr != pc`).
  - All entries are cleared and `pf_addr ← pc`.
  - `discard_cnt ←` number of allocated-unfilled entries, minus 1 if `mem_rvalid` is high in the same cycle.
  - If that count is 0, stay in RUN; otherwise go to FLUSH.
  - `inst_valid = 0` in the redirect cycle.
- `mem_rvalid` with no unfilled entry, in RUN or IDLE, is a protocol violation. The data is dropped and no state changes.
- Pop and allocate may occur in the same cycle. Fill and pop of the same entry may not: a fill becomes visible the following cycle, so there is no bypass.

## Timing
- Values during and after reset: `inst_valid = 0`, `mem_req = 0`, `mem_addr = 0`, `inst = 0`, state IDLE, `alloc_cnt = 0`, `discard_cnt = 0`, `pf_addr = 0`.
- Cold start, with `fetch_en` at cycle 0, ack at cycle 1, and memory latency L:
  - `mem_req` is first asserted at cycle 1.
  - `mem_rvalid` arrives at cycle 1+L.
  - The first `inst_valid` is at cycle 2+L.
- Throughput: with `DEPTH ≥ L+2`, sustained throughput is one instruction per cycle.
- Redirect penalty: from the redirect cycle to the new target, 2+L cycles plus the outstanding count drained in FLUSH.
- `reset` asserted mid-operation (including during FLUSH) returns everything to reset values on the next edge. Memory responses arriving after reset are dropped under the protocol-violation rule.

## Configuration
- `IFQ_STATS_EN` defined: adds ports `hit_cnt` out 16 and `redirect_cnt` out 16.
  - Both are saturating at 0xFFFF and reset to 0.
  - `hit_cnt` increments on every hit; `redirect_cnt` increments on every redirect.
- `IFQ_STATS_EN` undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset check: hold `reset` for 3 cycles with `fetch_en = 1` → `inst_valid`, `mem_req`, and `mem_addr` stay 0; the first `mem_req` appears 1 cycle after release.
- Sequential stream: `pc` = 0x0, 0x4, 0x8… with L = 1 and `mem_rdata = addr ^ 0xA5A5A5A5` → first `inst_valid` at cycle 3; then one instruction per cycle with correct data.
- Redirect with in-flight requests: set L = 3 and, with 2 requests outstanding, switch `pc` to 0x100 → state FLUSH; 2 responses dropped; `mem_addr = 0x100` issued after the drain; `inst = 0x100 ^ 0xA5A5A5A5`.
- Back-pressure: hold `fetch_en = 0` with DEPTH = 4 → exactly 4 requests issued, then `mem_req = 0`; resuming gives 4 back-to-back hits.
- Address wrap: start at `pc = 0xFFFFFFF8` → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; sequential fetch across the wrap causes no redirect.
- Reset during FLUSH, then late `mem_rvalid`: response ignored; IDLE reached; normal cold-start timing follows. With `IFQ_STATS_EN`: a run of 5 hits and 1 redirect reads `hit_cnt = 5`, `redirect_cnt = 1`.
